// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-ported RAM between an instruction-cache
// refill port (read only) and a data-cache port (read/write). Round-robin
// arbitration on contention, one transaction at a time, registered RAM
// strobes, and a bounded wait with a timeout error pulse.
module ram_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  // instruction cache
  input  logic             i_ic_req,
  input  logic [WIDTH-1:0] i_ic_addr,
  output logic [WIDTH-1:0] o_ic_data,
  output logic             o_ic_ack,
  // data cache
  input  logic             i_dc_req,
  input  logic             i_dc_we,
  input  logic [WIDTH-1:0] i_dc_addr,
  input  logic [WIDTH-1:0] i_dc_wdata,
  output logic [WIDTH-1:0] o_dc_rdata,
  output logic             o_dc_ack,
  // RAM
  output logic             o_ram_en,
  output logic             o_ram_we,
  output logic [WIDTH-1:0] o_ram_addr,
  output logic [WIDTH-1:0] o_ram_wdata,
  input  logic [WIDTH-1:0] i_ram_rdata,
  input  logic             i_ram_ready,
  // status
  output logic             o_busy,
  output logic             o_err,
  output logic             o_err_src
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IC = 2'd1,
    GNT_DC = 2'd2
  } state_e;

  // Wait counter is 8 bits wide, so TIMEOUT is expected to be 1..255.
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;   // 0 = IC, 1 = DC
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             ram_en_q, ram_en_d;
  logic             ram_we_q, ram_we_d;
  logic [WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic [WIDTH-1:0] ic_data_q, ic_data_d;
  logic [WIDTH-1:0] dc_rdata_q, dc_rdata_d;
  logic             ic_ack_q, ic_ack_d;
  logic             dc_ack_q, dc_ack_d;
  logic             err_q, err_d;
  logic             err_src_q, err_src_d;

  logic timeout_hit;
  assign timeout_hit = (wait_cnt_q == TIMEOUT_CNT);

  // State and all registered outputs; reset clears everything so every output reads 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      wait_cnt_q   <= '0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ic_data_q    <= '0;
      dc_rdata_q   <= '0;
      ic_ack_q     <= 1'b0;
      dc_ack_q     <= 1'b0;
      err_q        <= 1'b0;
      err_src_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ic_data_q    <= ic_data_d;
      dc_rdata_q   <= dc_rdata_d;
      ic_ack_q     <= ic_ack_d;
      dc_ack_q     <= dc_ack_d;
      err_q        <= err_d;
      err_src_q    <= err_src_d;
    end
  end

  // Next state: arbitrate in IDLE, leave a grant state on ready or timeout.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (i_ic_req && i_dc_req) state_d = last_grant_q ? GNT_IC : GNT_DC;
        else if (i_ic_req)        state_d = GNT_IC;
        else if (i_dc_req)        state_d = GNT_DC;
      end
      GNT_IC, GNT_DC: begin
        if (i_ram_ready || timeout_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: latch request on grant, finish on ready, else count or time out.
  always_comb begin
    ram_en_d     = ram_en_q;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ic_data_d    = ic_data_q;
    dc_rdata_d   = dc_rdata_q;
    wait_cnt_d   = wait_cnt_q;
    last_grant_d = last_grant_q;
    err_src_d    = err_src_q;
    ic_ack_d     = 1'b0;
    dc_ack_d     = 1'b0;
    err_d        = 1'b0;

    if (state_q == IDLE) begin
      if (state_d != IDLE) begin
        wait_cnt_d  = '0;
        ram_en_d    = 1'b1;
        ram_we_d    = (state_d == GNT_DC) && i_dc_we;
        ram_addr_d  = (state_d == GNT_DC) ? i_dc_addr : i_ic_addr;
        ram_wdata_d = (state_d == GNT_DC) ? i_dc_wdata : '0;
      end
    end else if (i_ram_ready) begin
      // Ready wins over a coincident timeout.
      ram_en_d     = 1'b0;
      ram_we_d     = 1'b0;
      wait_cnt_d   = '0;
      last_grant_d = (state_q == GNT_DC);
      if (state_q == GNT_IC) begin
        ic_ack_d  = 1'b1;
        ic_data_d = i_ram_rdata;
      end else begin
        dc_ack_d = 1'b1;
        if (!ram_we_q) dc_rdata_d = i_ram_rdata;
      end
    end else if (timeout_hit) begin
      ram_en_d     = 1'b0;
      ram_we_d     = 1'b0;
      wait_cnt_d   = '0;
      last_grant_d = (state_q == GNT_DC);
      err_d        = 1'b1;
      err_src_d    = (state_q == GNT_DC);
    end else begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  assign o_ram_en    = ram_en_q;
  assign o_ram_we    = ram_we_q;
  assign o_ram_addr  = ram_addr_q;
  assign o_ram_wdata = ram_wdata_q;
  assign o_ic_data   = ic_data_q;
  assign o_ic_ack    = ic_ack_q;
  assign o_dc_rdata  = dc_rdata_q;
  assign o_dc_ack    = dc_ack_q;
  assign o_err       = err_q;
  assign o_err_src   = err_src_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the data and address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of wait cycles per RAM transaction (8-bit counter).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 i_ic_req  in  1  instruction-cache refill read request; held high until o_ic_ack.
REQ-006 i_ic_addr  in  WIDTH  instruction-cache read address.
REQ-007 o_ic_data  out  WIDTH  read data for the instruction cache; valid while o_ic_ack is high.
REQ-008 o_ic_ack  out  1  one-cycle completion pulse for the instruction cache.
REQ-009 i_dc_req  in  1  data-cache request; held high until o_dc_ack.
REQ-010 i_dc_we  in  1  data-cache write (1) or read (0).
REQ-011 i_dc_addr, i_dc_wdata  in  WIDTH each  data-cache address and write data.
REQ-012 o_dc_rdata  out  WIDTH  data-cache read data; valid while o_dc_ack is high.
REQ-013 o_dc_ack  out  1  one-cycle completion pulse for the data cache.
REQ-014 o_ram_en, o_ram_we  out  1 each  RAM enable and write strobe, both registered.
REQ-015 o_ram_addr, o_ram_wdata  out  WIDTH each  RAM address and write data, both registered.
REQ-016 i_ram_rdata  in  WIDTH  RAM read data; valid when i_ram_ready is high.
REQ-017 i_ram_ready  in  1  RAM completion; sampled only while o_ram_en is high.
REQ-018 o_busy  out  1  high in any state other than IDLE.
REQ-019 o_err  out  1  one-cycle timeout pulse.
REQ-020 o_err_src  out  1  requester that timed out (0 = IC, 1 = DC); valid with o_err.

Function
REQ-021 The arbiter SHALL use three states: IDLE, GNT_IC, GNT_DC.
REQ-022 In IDLE with exactly one request high, the FSM SHALL move to that requester's grant state on the next edge.
REQ-023 In IDLE with both requests high, the FSM SHALL grant the requester not granted last (1-bit last_grant register, reset value IC, so DC wins first).
REQ-024 On the grant edge, the block SHALL latch the requester's address, we (IC: forced 0) and wdata into the o_ram_* registers and set o_ram_en=1.
REQ-025 Latency: request high in IDLE at cycle N -> o_ram_en=1 at N+1.
REQ-026 The o_ram_* outputs SHALL hold stable until the transaction ends, regardless of requester input changes.
REQ-027 When i_ram_ready=1 at cycle M in a grant state, the block SHALL, on that edge:
 - register i_ram_rdata into the granted requester's data output (write: data output unchanged);
 - pulse that ack for exactly one cycle (M+1);
 - clear o_ram_en and o_ram_we;
 - update last_grant;
 - return to IDLE.
REQ-028 The next grant's o_ram_en SHALL be asserted no earlier than M+2, giving at least one idle cycle between transactions.
REQ-029 i_ram_ready SHALL be ignored in IDLE.
REQ-030 A request dropped mid-transaction SHALL NOT abort the transaction; the ack is still pulsed.
REQ-031 The wait counter SHALL clear on grant and increment each grant-state cycle with i_ram_ready=0.
REQ-032 When the wait counter reaches TIMEOUT, the block SHALL, on the next edge:
 - pulse o_err with o_err_src set to the granted requester;
 - drop o_ram_en;
 - not pulse any ack;
 - update last_grant;
 - return to IDLE (a still-held request re-arbitrates).
REQ-033 If i_ram_ready and the timeout coincide, ready SHALL win: normal completion, no o_err.
REQ-034 o_ic_ack and o_dc_ack SHALL never be high in the same cycle.
REQ-035 o_ic_data and o_dc_rdata SHALL hold their last captured values between acks.

Reset
REQ-036 rst=0 SHALL immediately force state IDLE, last_grant=IC, wait counter=0 and every output to 0, including mid-transaction.
REQ-037 After rst deasserts, the first arbitration SHALL occur on the first rising edge with rst=1.

Verification
REQ-038 IC read only, addr 0x100, ready one cycle after en with rdata 0xDEADBEEF -> o_ram_en at N+1, o_ic_ack at N+3 with o_ic_data=0xDEADBEEF, o_busy low at N+3.
REQ-039 Both requesters held continuously, ready always 1 -> grants alternate DC, IC, DC, IC; acks never overlap.
REQ-040 DC write addr 0x40, wdata 0x12345678 -> o_ram_we=1, o_ram_wdata=0x12345678 held until ready; o_dc_ack pulses; o_dc_rdata unchanged.
REQ-041 Ready held low, TIMEOUT=4 -> o_err pulses with o_err_src=1 after 4 wait cycles, no ack, DC re-granted next.
REQ-042 rst pulled low while GNT_IC waits -> all outputs 0 asynchronously; after release, a held IC request is re-granted with no ack lost or duplicated.
